dlk_check_sched: RTL
====================

Name: dlk_check_sched

Overview:
- Sequenced controller and arbiter for the base-address table used by buffer-overflow (data-leak) detection.
- Serves two requesters: a register port (a new block base address) and a check port (is an access beyond the next higher base?).
- Owns a DEPTH-entry circular table and scans it one entry per cycle, replacing a wide combinational compare.
- Sits between the LSU-side tap that produces base/access addresses and the exception logic that consumes overflow flags.

Parameters:
- DEPTH, 32: table entries; power of 2, ≥2.
- AW, 32: address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- reg_valid_i  in  1  register request valid
- reg_ready_o  out  1  register request accepted this cycle
- reg_base_i  in  AW  base address to register
- chk_valid_i  in  1  check request valid
- chk_ready_o  out  1  check request accepted this cycle
- chk_base_i  in  AW  base of the block being accessed
- chk_addr_i  in  AW  actual access address
- rsp_valid_o  out  1  check result valid
- rsp_ready_i  in  1  consumer accepts result
- rsp_overflow_o  out  1  chk_addr > closest higher base
- rsp_bound_o  out  AW  closest higher base; all-ones if none
- busy_o  out  1  FSM not in IDLE
- count_o  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset (async, rst_i=1):
  - All valid bits cleared; cursor=0; FSM=IDLE.
  - reg_ready_o=0, chk_ready_o=0, rsp_valid_o=0, rsp_overflow_o=0, rsp_bound_o=0, busy_o=0, count_o=0.
  - Reset mid-scan aborts the operation; no response is produced.
- Request capture: ready is asserted only in IDLE with no pending response. A request is accepted when valid&&ready; its operands are latched at acceptance.
- Arbitration (IDLE, both valid): round-robin. A last_grant flag starts at CHK after reset, so REG wins the first tie. Exactly one ready is asserted per cycle.
- FSM states:
  - IDLE:
    - reg accepted -> REG_SCAN.
    - chk accepted -> CHK_SCAN.
  - REG_SCAN:
    - Index i runs 0..DEPTH-1, one entry per cycle.
    - A dup flag sets if valid[i] and mem[i]==base.
    - After the last index -> REG_WRITE.
  - REG_WRITE (1 cycle):
    - If !dup and base!=0: mem[cursor]<=base, valid[cursor]<=1, cursor<=cursor+1 (wraps mod DEPTH).
    - count_o saturates at DEPTH. When full, the oldest entry is overwritten.
    - Then -> IDLE.
    - Base 0 and duplicates are accepted but dropped.
  - CHK_SCAN:
    - bound starts at all-ones.
    - Per index: if valid[i] and mem[i]>chk_base and mem[i]<bound, then bound<=mem[i].
    - After the last index -> CHK_RSP.
  - CHK_RSP:
    - rsp_valid_o=1, rsp_bound_o=bound, rsp_overflow_o=(chk_addr>bound). Comparisons are unsigned.
    - Outputs are held stable until rsp_ready_i. The cycle rsp_valid&&rsp_ready -> IDLE.
- Latency:
  - Register: acceptance to next ready = DEPTH+2 cycles.
  - Check: acceptance to rsp_valid_o = DEPTH+1 cycles.
- Table is not modified during CHK_SCAN; a check reflects all writes completed before its acceptance.
- chk_addr equal to bound -> no overflow (strict compare).
- No higher base -> bound=all-ones, overflow=0.

Optional Feature:
- Macro DLK_STATS_EN.
- When defined:
  - Adds outputs stat_chk_o (32) and stat_ovf_o (32). These count completed check responses and those with overflow=1.
  - Both saturate at all-ones and reset to 0.
  - Adds input stat_clr_i (1), a synchronous clear; a clear wins over a simultaneous increment.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then register 0x1000, 0x2000, 0x3000 -> count_o=3, each reg_ready_o spaced DEPTH+2 cycles.
- With the table {0x1000,0x2000,0x3000}, check base=0x1000 addr=0x1FF0 -> rsp_bound_o=0x2000, overflow=0. Check addr=0x2004 -> overflow=1. Check addr=0x2000 -> overflow=0.
- Check base=0x3000 addr=0xFFFF0000 -> bound=0xFFFFFFFF, overflow=0. Register 0x2000 again -> count_o stays 3. Register 0x0 -> count_o unchanged.
- Register DEPTH+1 distinct bases 0x100·(k+1) -> count_o=DEPTH, slot 0 now holds 0x100·(DEPTH+1). Check base=0x50 addr=0x180 -> bound=0x200 (0x100 evicted), overflow=0.
- reg_valid_i and chk_valid_i held together from reset -> grants alternate REG, CHK, REG… Hold rsp_ready_i=0 for 5 cycles -> response stable, no new grant.
- Assert rst_i mid CHK_SCAN -> rsp_valid_o never rises, count_o=0, next check on the empty table -> bound=0xFFFFFFFF.
- With DLK_STATS_EN, run the three checks of the second scenario -> stat_chk_o=3, stat_ovf_o=1. Pulse stat_clr_i -> both 0.

Source files
------------

// File: rtl/dlk_check_sched.sv
// Sequenced base-address table for data-leak (buffer-overflow) detection: one entry scanned per cycle.
// Optional statistics counters are compiled in with `define DLK_STATS_EN.
module dlk_check_sched #(
    parameter int DEPTH = 32,
    parameter int AW    = 32,
    localparam int IW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          reg_valid_i,
    output logic          reg_ready_o,
    input  logic [AW-1:0] reg_base_i,
    input  logic          chk_valid_i,
    output logic          chk_ready_o,
    input  logic [AW-1:0] chk_base_i,
    input  logic [AW-1:0] chk_addr_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_overflow_o,
    output logic [AW-1:0] rsp_bound_o,
    output logic          busy_o,
`ifdef DLK_STATS_EN
    input  logic          stat_clr_i,
    output logic [31:0]   stat_chk_o,
    output logic [31:0]   stat_ovf_o,
`endif
    output logic [CW-1:0] count_o
);

    typedef enum logic [2:0] {
        IDLE,
        REG_SCAN,
        REG_WRITE,
        CHK_SCAN,
        CHK_RSP
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   idx_reg;
    logic [IW-1:0]   cursor_reg;
    logic [CW-1:0]   count_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]   mem [DEPTH];
    logic [AW-1:0]   rd_data_reg;
    logic [IW-1:0]   rd_addr;
    logic [AW-1:0]   op_base_reg;
    logic [AW-1:0]   op_addr_reg;
    logic [AW-1:0]   bound_reg;
    logic            dup_reg;
    logic            last_chk_reg;
    logic            grant_reg;
    logic            grant_chk;
    logic            last_idx;
    logic            write_en;
    logic            entry_valid;

    assign last_idx    = (idx_reg == IW'(DEPTH - 1));
    assign write_en    = !dup_reg && (op_base_reg != '0);
    assign entry_valid = valid_reg[idx_reg];

    always_comb begin
        state_next = state_reg;
        grant_reg  = 1'b0;
        grant_chk  = 1'b0;
        case (state_reg)
            IDLE: begin
                // Round-robin: on a tie the requester not served last time wins.
                if (!rst_i) begin
                    if (reg_valid_i && (!chk_valid_i || last_chk_reg)) begin
                        grant_reg  = 1'b1;
                        state_next = REG_SCAN;
                    end else if (chk_valid_i) begin
                        grant_chk  = 1'b1;
                        state_next = CHK_SCAN;
                    end
                end
            end
            REG_SCAN:  if (last_idx) state_next = REG_WRITE;
            REG_WRITE: state_next = IDLE;
            CHK_SCAN:  if (last_idx) state_next = CHK_RSP;
            CHK_RSP:   if (rsp_ready_i) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            cursor_reg   <= '0;
            count_reg    <= '0;
            valid_reg    <= '0;
            op_base_reg  <= '0;
            op_addr_reg  <= '0;
            bound_reg    <= '0;
            dup_reg      <= 1'b0;
            last_chk_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    idx_reg <= '0;
                    dup_reg <= 1'b0;
                    if (grant_reg || grant_chk) begin
                        op_base_reg  <= grant_reg ? reg_base_i : chk_base_i;
                        op_addr_reg  <= chk_addr_i;
                        last_chk_reg <= grant_chk;
                    end
                    if (grant_chk) bound_reg <= '1;
                end
                REG_SCAN: begin
                    if (entry_valid && rd_data_reg == op_base_reg) dup_reg <= 1'b1;
                    idx_reg <= idx_reg + 1'b1;
                end
                REG_WRITE: begin
                    // Circular write: once full, the oldest entry is the one overwritten.
                    if (write_en) begin
                        valid_reg[cursor_reg] <= 1'b1;
                        cursor_reg <= cursor_reg + 1'b1;
                        if (count_reg != CW'(DEPTH)) count_reg <= count_reg + 1'b1;
                    end
                end
                CHK_SCAN: begin
                    if (entry_valid && rd_data_reg > op_base_reg && rd_data_reg < bound_reg)
                        bound_reg <= rd_data_reg;
                    idx_reg <= idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Read address runs one entry ahead of idx_reg so the registered read lines up with the scan.
    assign rd_addr = (state_reg == REG_SCAN || state_reg == CHK_SCAN) ? idx_reg + 1'b1 : '0;

    always_ff @(posedge clk_i) begin
        if (state_reg == REG_WRITE && write_en) mem[cursor_reg] <= op_base_reg;
        rd_data_reg <= mem[rd_addr];
    end

    assign reg_ready_o    = grant_reg;
    assign chk_ready_o    = grant_chk;
    assign rsp_valid_o    = (state_reg == CHK_RSP);
    assign rsp_bound_o    = bound_reg;
    assign rsp_overflow_o = (state_reg == CHK_RSP) && (op_addr_reg > bound_reg);
    assign busy_o         = (state_reg != IDLE);
    assign count_o        = count_reg;

`ifdef DLK_STATS_EN
    logic [31:0] stat_chk_reg;
    logic [31:0] stat_ovf_reg;
    logic        rsp_fire;

    assign rsp_fire = rsp_valid_o && rsp_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_chk_reg <= '0;
            stat_ovf_reg <= '0;
        end else if (stat_clr_i) begin
            stat_chk_reg <= '0;
            stat_ovf_reg <= '0;
        end else if (rsp_fire) begin
            if (stat_chk_reg != '1) stat_chk_reg <= stat_chk_reg + 1'b1;
            if (rsp_overflow_o && stat_ovf_reg != '1) stat_ovf_reg <= stat_ovf_reg + 1'b1;
        end
    end

    assign stat_chk_o = stat_chk_reg;
    assign stat_ovf_o = stat_ovf_reg;
`endif

endmodule
